uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter: accepts a parallel data word over a valid/ready handshake and shifts it out on `tx` as start bit, LSB-first data bits, optional even parity, and stop bits, each held for a fixed number of clock cycles. It is the transmit-side counterpart of the UART receiver. It sits between the CPU/MMIO side of the design and the board TX pin, and uses the same `CLK_FREQ`/`BAUD_RATE` parameterisation so both directions agree on bit timing.

## Interface

Parameters:
- `CLK_FREQ`, default 100000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame, legal values 1 or 2.

Ports:
- `clk` — in, 1: clock.
- `reset` — in, 1: reset, synchronous, active-high.
- `tx_data` — in, DATA_BITS: word to send; sampled only on handshake.
- `tx_valid` — in, 1: `tx_data` is valid.
- `tx_ready` — out, 1: block is idle and can accept a word.
- `tx` — out, 1: serial line, idles high.
- `tx_done` — out, 1: one-cycle pulse when a frame's last stop bit completes.

## Operation

- Constant `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, integer division truncated. Bit counter width is `$clog2(CLKS_PER_BIT)`; clock counter counts 0..CLKS_PER_BIT-1 and then wraps.
- States:
  - IDLE: `tx`=1, `tx_ready`=1.
    - Transition: `tx_valid && tx_ready` at a rising edge → latch `tx_data` into the shift register, clear counters, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0]. After CLKS_PER_BIT cycles, shift right and increment the bit index. After DATA_BITS bits, go to PARITY if `UART_TX_PARITY_EN` is defined, otherwise go to STOP.
  - PARITY: `tx` = XOR of the latched data (even parity) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE with a `tx_done` pulse.
- `tx_ready` is 0 in every state other than IDLE. `tx_valid` and `tx_data` changes outside IDLE are ignored and never corrupt the frame in flight.
- `tx` is driven from a register. No combinational path exists from inputs to `tx`.
- Reset values:
  - Outputs: `tx`=1, `tx_ready`=1, `tx_done`=0.
  - Internal: state IDLE, counters 0, shift register 0.
- Reset mid-frame aborts the frame. `tx` returns high on the cycle after the reset edge, and no `tx_done` is emitted.
- If reset and `tx_valid` are asserted together, reset wins and no word is accepted.

## Timing

- Handshake edge N: `tx` falls at N+1. The start bit covers cycles N+1..N+CLKS_PER_BIT.
- Data bit k occupies cycles N+1+(1+k)·CLKS_PER_BIT through N+(2+k)·CLKS_PER_BIT.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT cycles, where P=1 with parity and P=0 without.
- `tx_done`=1 and `tx_ready`=1 in cycle N+F+1, i.e. the first cycle back in IDLE.
- Back-to-back transfers: if `tx_valid` is held high, the next handshake occurs in cycle N+F+1. The next start bit therefore begins at N+F+2, giving exactly one extra idle-high cycle between frames.

## Configuration

- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in and each frame carries one even-parity bit between the data bits and the stop bits.
  - Undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.
- The receiver must be built with the matching setting.

## Structure

- Shared package `uart_pkg` holds:
  - the state encoding enum (IDLE/START/DATA/PARITY/STOP);
  - the helper function for `CLKS_PER_BIT` and counter widths;
  - the default `CLK_FREQ`/`BAUD_RATE` constants shared with the receiver.
- Sub-module: `uart_baud_tick`. It is a counter producing a one-cycle tick every CLKS_PER_BIT cycles and is restartable by a `clear` input. The transmitter clears it on handshake and advances bits on each tick.

## Test plan

All scenarios use CLK_FREQ=1000000 and BAUD_RATE=100000, giving CLKS_PER_BIT=10.

- Reset, then idle 50 cycles → `tx`=1, `tx_ready`=1, `tx_done`=0 throughout.
- Send 0x55 with parity off → `tx` pattern 0,1,0,1,0,1,0,1,0,1, each level held 10 cycles. `tx_done` pulses at handshake+101 and the bus is otherwise silent.
- Send 0xA5 with `UART_TX_PARITY_EN` defined → parity bit 0 (four ones) and a frame of 110 cycles. Send 0x07 → parity bit 1.
- `tx_valid` held high with 0x01 then 0x80 → two frames, start bits at N+1 and N+102. `tx_data` is changed mid-frame and the first frame is unaffected.
- Reset asserted at cycle 35 of a frame → `tx`=1 from the next cycle, no `tx_done`, and `tx_ready`=1. A new word sent afterwards transmits correctly.
- STOP_BITS=2 and DATA_BITS=7, send 0x7F → stop high for 20 cycles, frame of 100 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit-timing helpers, parity helper
// and the default clock/baud constants used by both transmitter and receiver.
package uart_pkg;

   localparam int UART_CLK_FREQ  = 32'd100_000_000;
   localparam int UART_BAUD_RATE = 32'd115_200;

   // Frame state encoding (legacy-compatible constants)
   typedef logic [2:0] uart_state_t;
   localparam uart_state_t ST_IDLE   = 3'd0;
   localparam uart_state_t ST_START  = 3'd1;
   localparam uart_state_t ST_DATA   = 3'd2;
   localparam uart_state_t ST_PARITY = 3'd3;
   localparam uart_state_t ST_STOP   = 3'd4;

   // Clock cycles per bit, truncating division
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 32'sd1) ? $clog2(n) : 32'sd1;
   endfunction

   // Even parity over a zero-extended data word
   function automatic logic even_parity(input logic [8:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a one-cycle tick every CLKS_PER_BIT cycles.
// Asserting clear restarts the period so the next tick lands CLKS_PER_BIT
// cycles later.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int CNT_W        = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_r;

   // Count 0..CLKS_PER_BIT-1 and wrap; clear restarts the period
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (count_r == LAST_CNT) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign tick = (count_r == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even
// parity bit, STOP_BITS stop bits. The parity bit is compiled in only when
// UART_TX_PARITY_EN is defined. tx, tx_ready and tx_done are all registered.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = UART_CLK_FREQ,
   parameter int BAUD_RATE = UART_BAUD_RATE,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_done
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W        = cnt_width(CLKS_PER_BIT);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   uart_state_t          state_r, state_nxt_s;
   logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
   logic [3:0]           bit_idx_r, bit_idx_nxt_s;
   logic                 tx_r, tx_nxt_s;
   logic                 ready_r, done_r, done_nxt_s;
   logic                 handshake_s, tick_s;
`ifdef UART_TX_PARITY_EN
   logic                 parity_r;
   logic [8:0]           data9_s;
`endif

   assign handshake_s = tx_valid && (state_r == ST_IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_baud_tick (
      .clk   (clk),
      .reset (reset),
      .clear (handshake_s),
      .tick  (tick_s)
   );

`ifdef UART_TX_PARITY_EN
   // Zero-extend the incoming word for the parity helper
   always_comb begin
      data9_s                = 9'd0;
      data9_s[DATA_BITS-1:0] = tx_data;
   end
`endif

   // Next-state, shift and bit-index logic; one bit advance per baud tick
   always_comb begin
      state_nxt_s   = state_r;
      shift_nxt_s   = shift_r;
      bit_idx_nxt_s = bit_idx_r;
      done_nxt_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (handshake_s) begin
               state_nxt_s   = ST_START;
               shift_nxt_s   = tx_data;
               bit_idx_nxt_s = 4'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
               if (bit_idx_r == LAST_DATA) begin
                  bit_idx_nxt_s = 4'd0;
`ifdef UART_TX_PARITY_EN
                  state_nxt_s   = ST_PARITY;
`else
                  state_nxt_s   = ST_STOP;
`endif
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 4'd1;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick_s) begin
               state_nxt_s = ST_STOP;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (tick_s) begin
               if (bit_idx_r == LAST_STOP) begin
                  state_nxt_s   = ST_IDLE;
                  bit_idx_nxt_s = 4'd0;
                  done_nxt_s    = 1'b1;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 4'd1;
               end
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            bit_idx_nxt_s = 4'd0;
         end
      endcase
   end

   // Line level for the state being entered, so tx changes with the state
   always_comb begin
      tx_nxt_s = 1'b1;
      case (state_nxt_s)
         ST_IDLE:   tx_nxt_s = 1'b1;
         ST_START:  tx_nxt_s = 1'b0;
         ST_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_nxt_s = parity_r;
`endif
         ST_STOP:   tx_nxt_s = 1'b1;
         default:   tx_nxt_s = 1'b1;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         shift_r   <= '0;
         bit_idx_r <= 4'd0;
         tx_r      <= 1'b1;
         ready_r   <= 1'b1;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         shift_r   <= shift_nxt_s;
         bit_idx_r <= bit_idx_nxt_s;
         tx_r      <= tx_nxt_s;
         ready_r   <= (state_nxt_s == ST_IDLE);
         done_r    <= done_nxt_s;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Parity is captured at handshake because the shift register is consumed
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_r <= 1'b0;
      end else if (handshake_s) begin
         parity_r <= even_parity(data9_s);
      end else begin
         parity_r <= parity_r;
      end
   end
`endif

   assign tx       = tx_r;
   assign tx_ready = ready_r;
   assign tx_done  = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances (8N1-style and 7-bit/2-stop),
// expected line levels derived from the frame layout for each cycle.
// Frame expectations follow UART_TX_PARITY_EN if it is defined at compile.
module tb_uart_tx;

   localparam int C = 10;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FA = C * (1 + 8 + P + 1);
   localparam int FB = C * (1 + 7 + P + 2);

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_a = 8'd0;
   logic       valid_a = 1'b0;
   logic       ready_a, tx_a, done_a;
   logic [6:0] data_b = 7'd0;
   logic       valid_b = 1'b0;
   logic       ready_b, tx_b, done_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .tx_data(data_a), .tx_valid(valid_a),
      .tx_ready(ready_a), .tx(tx_a), .tx_done(done_a));

   uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset(reset), .tx_data(data_b), .tx_valid(valid_b),
      .tx_ready(ready_b), .tx(tx_b), .tx_done(done_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Expected tx at cycle j (1-based) after the handshake edge
   function automatic logic exp_level(input int j, input logic [8:0] d, input int db);
      int b;
      b = (j - 1) / C;
      if (b == 0) return 1'b0;
      if (b <= db) return d[b-1];
      if (P == 1 && b == db + 1) return ^d;
      return 1'b1;
   endfunction

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_tx_a", 32'(tx_a), 32'd1);
         chk("idle_rdy_a", 32'(ready_a), 32'd1);
         chk("idle_done_a", 32'(done_a), 32'd0);
         chk("idle_tx_b", 32'(tx_b), 32'd1);
         chk("idle_done_b", 32'(done_b), 32'd0);
      end
   endtask

   task automatic start_word(input bit sel, input logic [8:0] d);
      @(negedge clk);
      chk("ready_pre", 32'(sel ? ready_b : ready_a), 32'd1);
      if (sel) begin
         data_b = d[6:0];
         valid_b = 1'b1;
      end else begin
         data_a = d[7:0];
         valid_a = 1'b1;
      end
      @(posedge clk);
   endtask

   // mode 0: drop valid and inject ignored noise; mode 1: hold valid, change data
   task automatic watch_frame(input bit sel, input logic [8:0] d, input int mode);
      int db, f;
      logic t, r, dn;
      db = sel ? 7 : 8;
      f  = sel ? FB : FA;
      for (int j = 1; j <= f + 1; j++) begin
         @(negedge clk);
         t  = sel ? tx_b : tx_a;
         r  = sel ? ready_b : ready_a;
         dn = sel ? done_b : done_a;
         if (j <= f) begin
            chk($sformatf("tx%0d_d%0h_j%0d", sel, d, j), 32'(t), 32'(exp_level(j, d, db)));
            chk($sformatf("rdy%0d_j%0d", sel, j), 32'(r), 32'd0);
            chk($sformatf("done%0d_j%0d", sel, j), 32'(dn), 32'd0);
         end else begin
            chk($sformatf("tx%0d_end", sel), 32'(t), 32'd1);
            chk($sformatf("rdy%0d_end", sel), 32'(r), 32'd1);
            chk($sformatf("done%0d_end", sel), 32'(dn), 32'd1);
         end
         if (mode == 0) begin
            if (j == 1 || j == 41) begin
               if (sel) valid_b = 1'b0; else valid_a = 1'b0;
            end else if (j == 40) begin
               if (sel) begin valid_b = 1'b1; data_b = 7'd0; end
               else begin valid_a = 1'b1; data_a = 8'd0; end
            end
         end else begin
            if (j == 30) data_a = 8'hFF;
            if (j == 60) data_a = 8'h80;
         end
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx", 32'(tx_a), 32'd1);
      chk("rst_rdy", 32'(ready_a), 32'd1);
      chk("rst_done", 32'(done_a), 32'd0);
      reset = 1'b0;
      idle_check(50);

      // Single frames on the 8-bit instance
      start_word(1'b0, 9'h055);
      watch_frame(1'b0, 9'h055, 0);
      idle_check(5);
      start_word(1'b0, 9'h0A5);
      watch_frame(1'b0, 9'h0A5, 0);
      idle_check(3);
      start_word(1'b0, 9'h007);
      watch_frame(1'b0, 9'h007, 0);
      idle_check(3);

      // Back-to-back with valid held; data changes during the first frame
      start_word(1'b0, 9'h001);
      watch_frame(1'b0, 9'h001, 1);
      watch_frame(1'b0, 9'h080, 0);
      idle_check(3);

      // Reset in cycle 35 of a frame aborts it silently
      start_word(1'b0, 9'h0C3);
      for (int j = 1; j <= 35; j++) begin
         @(negedge clk);
         chk($sformatf("abort_tx_j%0d", j), 32'(tx_a), 32'(exp_level(j, 9'h0C3, 8)));
         if (j == 1) valid_a = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("abort_tx", 32'(tx_a), 32'd1);
      chk("abort_rdy", 32'(ready_a), 32'd1);
      chk("abort_done", 32'(done_a), 32'd0);
      reset = 1'b0;
      idle_check(120);
      start_word(1'b0, 9'h03C);
      watch_frame(1'b0, 9'h03C, 0);
      idle_check(3);

      // Reset and valid together: reset wins, nothing is sent
      @(negedge clk);
      reset = 1'b1;
      valid_a = 1'b1;
      data_a = 8'h00;
      @(negedge clk);
      chk("rstv_tx", 32'(tx_a), 32'd1);
      chk("rstv_rdy", 32'(ready_a), 32'd1);
      reset = 1'b0;
      valid_a = 1'b0;
      idle_check(15);

      // 7 data bits, 2 stop bits
      start_word(1'b1, 9'h07F);
      watch_frame(1'b1, 9'h07F, 0);
      idle_check(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
